// File: rtl/rect_cmd_queue.sv
// Rectangle command queue: FIFO of corner-normalised draw commands, issued one at a
// time to the draw engine. Define RECT_CMD_CLIP_EN to clamp coordinates on push.
module rect_cmd_queue #(
  parameter int                          SPIXEL_X_WIDTH = 6,
  parameter int                          SPIXEL_Y_WIDTH = 6,
  parameter logic [SPIXEL_X_WIDTH-1:0]   SPIXEL_X_MAX   = 6'd63,
  parameter logic [SPIXEL_Y_WIDTH-1:0]   SPIXEL_Y_MAX   = 6'd47,
  parameter int                          COLOR_ID_WIDTH = 8,
  parameter int                          DEPTH_LOG2     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPIXEL_X_WIDTH-1:0] cmd_x0,
  input  logic [SPIXEL_X_WIDTH-1:0] cmd_x1,
  input  logic [SPIXEL_Y_WIDTH-1:0] cmd_y0,
  input  logic [SPIXEL_Y_WIDTH-1:0] cmd_y1,
  input  logic [COLOR_ID_WIDTH-1:0] cmd_color,
  input  logic                      cmd_vld,
  output logic                      cmd_rdy,
  output logic [SPIXEL_X_WIDTH-1:0] ox0,
  output logic [SPIXEL_X_WIDTH-1:0] ox1,
  output logic [SPIXEL_Y_WIDTH-1:0] oy0,
  output logic [SPIXEL_Y_WIDTH-1:0] oy1,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      odata_vld,
  input  logic                      idone,
  output logic                      obusy,
  output logic [DEPTH_LOG2:0]       ocount,
  output logic [1:0]                dbg_state
);

  localparam int XW      = SPIXEL_X_WIDTH;
  localparam int YW      = SPIXEL_Y_WIDTH;
  localparam int CLW     = COLOR_ID_WIDTH;
  localparam int PW      = DEPTH_LOG2;
  localparam int NW      = DEPTH_LOG2 + 1;
  localparam int ENTRY_W = 2*XW + 2*YW + CLW;
  localparam logic [NW-1:0] DEPTH_C = NW'(1 << DEPTH_LOG2);

`ifdef RECT_CMD_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [ENTRY_W-1:0] mem_q [1 << DEPTH_LOG2];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]      count_q, count_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  state_t             state_q, state_d;
  logic [XW-1:0]      ox0_q, ox0_d, ox1_q, ox1_d;
  logic [YW-1:0]      oy0_q, oy0_d, oy1_q, oy1_d;
  logic [CLW-1:0]     odata_q, odata_d;
  logic               vld_q, vld_d, busy_q, busy_d;

  logic               push, pop;
  logic [XW-1:0]      x0_c, x1_c, hx0, hx1;
  logic [YW-1:0]      y0_c, y1_c, hy0, hy1;
  logic [CLW-1:0]     hcol;
  logic [ENTRY_W-1:0] wr_entry;

  // Clamp (optional) then order corners so the engine always gets lo <= hi.
  always_comb begin
    x0_c = (CLIP_EN && (cmd_x0 > SPIXEL_X_MAX)) ? SPIXEL_X_MAX : cmd_x0;
    x1_c = (CLIP_EN && (cmd_x1 > SPIXEL_X_MAX)) ? SPIXEL_X_MAX : cmd_x1;
    y0_c = (CLIP_EN && (cmd_y0 > SPIXEL_Y_MAX)) ? SPIXEL_Y_MAX : cmd_y0;
    y1_c = (CLIP_EN && (cmd_y1 > SPIXEL_Y_MAX)) ? SPIXEL_Y_MAX : cmd_y1;
    wr_entry = {(x0_c <= x1_c) ? x0_c : x1_c,
                (x0_c <= x1_c) ? x1_c : x0_c,
                (y0_c <= y1_c) ? y0_c : y1_c,
                (y0_c <= y1_c) ? y1_c : y0_c,
                cmd_color};
    {hx0, hx1, hy0, hy1, hcol} = mem_q[rd_ptr_q];
  end

  // Handshake: a push is accepted on cmd_vld & cmd_rdy; cmd_rdy is registered from
  // the next occupancy, so a full queue rejects pushes even in a popping cycle.
  always_comb begin
    push      = cmd_vld & cmd_rdy_q;
    pop       = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + NW'(push) - NW'(pop);
    cmd_rdy_d = (count_d != DEPTH_C);
  end

  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    ox0_d   = ox0_q;
    ox1_d   = ox1_q;
    oy0_d   = oy0_q;
    oy1_d   = oy1_q;
    odata_d = odata_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          ox0_d   = hx0;
          ox1_d   = hx1;
          oy0_d   = hy0;
          oy1_d   = hy1;
          odata_d = hcol;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (idone) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cmd_rdy_q <= 1'b1;
      state_q   <= IDLE;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      ox0_q     <= '0;
      ox1_q     <= '0;
      oy0_q     <= '0;
      oy1_q     <= '0;
      odata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cmd_rdy_q <= cmd_rdy_d;
      state_q   <= state_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      ox0_q     <= ox0_d;
      ox1_q     <= ox1_d;
      oy0_q     <= oy0_d;
      oy1_q     <= oy1_d;
      odata_q   <= odata_d;
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign ox0       = ox0_q;
  assign ox1       = ox1_q;
  assign oy0       = oy0_q;
  assign oy1       = oy1_q;
  assign odata     = odata_q;
  assign odata_vld = vld_q;
  assign obusy     = busy_q;
  assign ocount    = count_q;
  assign dbg_state = state_q;

endmodule
